// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the run/halt/step debug controller: FSM states,
// host command opcodes and the breakpoint-disable argument value.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_HALT = 2'd1,
    S_RUN  = 2'd2,
    S_STEP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_RUN    = 2'd0,
    CMD_HALT   = 2'd1,
    CMD_STEP   = 2'd2,
    CMD_SET_BP = 2'd3
  } cmd_e;

  // Wide enough for any supported PC_W; users take the low PC_W bits.
  localparam logic [63:0] BP_DISABLE = '1;

endpackage

// File: rtl/cpu_run_ctrl_bp_compare.sv
// Single hardware breakpoint: holds the address, enable and the one-shot
// skip that lets a resumed core execute the instruction it stopped on.
module bp_compare
  import cpu_dbg_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_bp,
  input  logic [PC_W-1:0] set_arg,
  input  logic            arm_skip,
  input  logic            pc_en,
  input  logic [PC_W-1:0] pc,
  output logic            bp_block
);

  localparam logic [PC_W-1:0] BP_OFF = BP_DISABLE[PC_W-1:0];

  logic [PC_W-1:0] bp_addr_q, bp_addr_d;
  logic            bp_en_q, bp_en_d;
  logic            skip_bp_q, skip_bp_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_addr_q <= '0;
      bp_en_q   <= 1'b0;
      skip_bp_q <= 1'b0;
    end else begin
      bp_addr_q <= bp_addr_d;
      bp_en_q   <= bp_en_d;
      skip_bp_q <= skip_bp_d;
    end
  end

  always_comb begin
    bp_addr_d = bp_addr_q;
    bp_en_d   = bp_en_q;
    skip_bp_d = skip_bp_q;
    if (set_bp) begin
      if (set_arg == BP_OFF) begin
        bp_en_d = 1'b0;
      end else begin
        bp_addr_d = set_arg;
        bp_en_d   = 1'b1;
      end
    end
    // Arming only happens from halt (pc_en=0), so the two never collide.
    if (pc_en)    skip_bp_d = 1'b0;
    if (arm_skip) skip_bp_d = 1'b1;
  end

  assign bp_block = bp_en_q && (pc == bp_addr_q) && !skip_bp_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer for the single-cycle core: gates PCEn,
// stops on breakpoint or invalid instruction, counts retired instructions.
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int CNT_W    = 32,
  parameter int RST_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [PC_W-1:0]  cmd_arg,
  input  logic [PC_W-1:0]  pc,
  input  logic             invalid_inst,
  output logic             pc_en,
  output logic             halted,
  output logic             bp_hit,
  output logic             err,
  output logic [CNT_W-1:0] retired,
  output logic [1:0]       state
);

  localparam logic [3:0] HOLD_INIT = 4'(RST_HOLD);

  state_e           state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic             bp_hit_q, bp_hit_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic accept;
  logic set_bp;
  logic arm_skip;
  logic bp_block;

  bp_compare #(
    .PC_W(PC_W)
  ) u_bp (
    .clk     (clk),
    .rst     (rst),
    .set_bp  (set_bp),
    .set_arg (cmd_arg),
    .arm_skip(arm_skip),
    .pc_en   (pc_en),
    .pc      (pc),
    .bp_block(bp_block)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      hold_q    <= HOLD_INIT;
      bp_hit_q  <= 1'b0;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      bp_hit_q  <= bp_hit_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    accept    = cmd_valid && cmd_ready;
    set_bp    = accept && (cmd_op == CMD_SET_BP);
    arm_skip  = 1'b0;
    state_d   = state_q;
    hold_d    = hold_q;
    bp_hit_d  = bp_hit_q;
    err_d     = err_q;
    retired_d = retired_q + CNT_W'(pc_en);
    case (state_q)
      S_INIT: begin
        hold_d = hold_q - 4'd1;
        if (hold_q == 4'd1) state_d = S_HALT;
      end
      S_HALT: begin
        if (accept && (cmd_op == CMD_RUN || cmd_op == CMD_STEP)) begin
          state_d  = (cmd_op == CMD_RUN) ? S_RUN : S_STEP;
          arm_skip = 1'b1;
          bp_hit_d = 1'b0;
          err_d    = 1'b0;
        end
      end
      S_RUN: begin
        // Stop causes are independent; each sets its own sticky flag.
        if (bp_block) begin
          state_d  = S_HALT;
          bp_hit_d = 1'b1;
        end
        if (pc_en && invalid_inst) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
        if (accept && cmd_op == CMD_HALT) state_d = S_HALT;
      end
      S_STEP: begin
        state_d = S_HALT;
        if (invalid_inst) err_d = 1'b1;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    pc_en     = ((state_q == S_RUN) && !bp_block) || (state_q == S_STEP);
    cmd_ready = (state_q != S_INIT);
    halted    = (state_q == S_HALT);
  end

  assign bp_hit  = bp_hit_q;
  assign err     = err_q;
  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: reset hold, run/halt counting, a
// table of breakpoint/step/disable vectors, invalid-instruction and reset-mid-run.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [31:0] pc;
  logic        invalid_inst;
  logic        pc_en;
  logic        halted;
  logic        bp_hit;
  logic        err;
  logic [31:0] retired;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;
  bit pc_track = 1'b0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.PC_W(32), .CNT_W(32), .RST_HOLD(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_arg     (cmd_arg),
    .pc          (pc),
    .invalid_inst(invalid_inst),
    .pc_en       (pc_en),
    .halted      (halted),
    .bp_hit      (bp_hit),
    .err         (err),
    .retired     (retired),
    .state       (state)
  );

  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic [31:0] arg;
    logic [31:0] pc;
    logic        inv;
    logic        e_pc_en;
    logic [1:0]  e_state;
    logic        e_bp_hit;
    logic        e_err;
    logic [31:0] e_ret;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [1:0] op, input logic [31:0] arg,
                     input logic [31:0] p, input logic inv, input logic en,
                     input logic [1:0] st, input logic bh, input logic er,
                     input logic [31:0] ret);
    vec_t r;
    r.v = v; r.op = op; r.arg = arg; r.pc = p; r.inv = inv;
    r.e_pc_en = en; r.e_state = st; r.e_bp_hit = bh; r.e_err = er; r.e_ret = ret;
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: sample pc_en before the edge, advance the bench PC if it executed.
  task automatic cyc();
    logic en;
    #1;
    en = pc_en;
    @(posedge clk);
    #1;
    if (pc_track && en) pc = pc + 32'd1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    cyc();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = '0;
    pc = '0; invalid_inst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_pc_en", pc_en, 0);
    chk("rst_state", state, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("init%0d_state", i), state, 0);
      chk($sformatf("init%0d_pc_en", i), pc_en, 0);
      chk($sformatf("init%0d_ready", i), cmd_ready, 0);
      @(posedge clk); #1;
    end
    chk("post_init_halted", halted, 1);
    chk("post_init_ready", cmd_ready, 1);
    chk("post_init_retired", retired, 0);

    // RUN for 10 cycles, then HALT; the HALT-accepting cycle also retires.
    pc_track = 1'b1;
    send(2'd0, 32'd0);
    chk("run_state", state, 2);
    repeat (10) cyc();
    chk("run10_retired", retired, 10);
    send(2'd1, 32'd0);
    chk("halt_retired", retired, 11);
    chk("halt_halted", halted, 1);
    chk("halt_err", err, 0);
    chk("halt_bp_hit", bp_hit, 0);
    chk("halt_pc", pc, 11);
    pc_track = 1'b0;

    // Breakpoint at 8, resume past it, three single steps, then disable.
    add(1, 2'd3, 32'd8, 0, 0, 0, 2'd1, 0, 0, 11);
    add(1, 2'd0, 32'd0, 0, 0, 0, 2'd1, 0, 0, 11);
    for (int p = 0; p < 8; p++) add(0, 2'd0, 0, p, 0, 1, 2'd2, 0, 0, 32'(11 + p));
    add(0, 2'd0, 0, 8, 0, 0, 2'd2, 0, 0, 19);
    add(0, 2'd0, 0, 8, 0, 0, 2'd1, 1, 0, 19);
    add(1, 2'd0, 0, 8, 0, 0, 2'd1, 1, 0, 19);
    add(0, 2'd0, 0, 8, 0, 1, 2'd2, 0, 0, 19);
    add(0, 2'd0, 0, 9, 0, 1, 2'd2, 0, 0, 20);
    add(1, 2'd1, 0, 10, 0, 1, 2'd2, 0, 0, 21);
    add(0, 2'd0, 0, 11, 0, 0, 2'd1, 0, 0, 22);
    for (int k = 0; k < 3; k++) begin
      add(1, 2'd2, 0, 32'(3 + k), 0, 0, 2'd1, 0, 0, 32'(22 + k));
      add(0, 2'd0, 0, 32'(3 + k), 0, 1, 2'd3, 0, 0, 32'(22 + k));
    end
    add(0, 2'd0, 0, 6, 0, 0, 2'd1, 0, 0, 25);
    add(1, 2'd3, 32'hFFFF_FFFF, 6, 0, 0, 2'd1, 0, 0, 25);
    add(1, 2'd0, 0, 6, 0, 0, 2'd1, 0, 0, 25);
    add(0, 2'd0, 0, 7, 0, 1, 2'd2, 0, 0, 25);
    add(0, 2'd0, 0, 8, 0, 1, 2'd2, 0, 0, 26);
    add(1, 2'd1, 0, 9, 0, 1, 2'd2, 0, 0, 27);
    add(0, 2'd0, 0, 10, 0, 0, 2'd1, 0, 0, 28);

    foreach (tbl[i]) begin
      cmd_valid    = tbl[i].v;
      cmd_op       = tbl[i].op;
      cmd_arg      = tbl[i].arg;
      pc           = tbl[i].pc;
      invalid_inst = tbl[i].inv;
      #1;
      chk($sformatf("v%0d_pc_en", i), pc_en, tbl[i].e_pc_en);
      chk($sformatf("v%0d_state", i), state, tbl[i].e_state);
      chk($sformatf("v%0d_halted", i), halted, tbl[i].e_state == 2'd1);
      chk($sformatf("v%0d_bp_hit", i), bp_hit, tbl[i].e_bp_hit);
      chk($sformatf("v%0d_err", i), err, tbl[i].e_err);
      chk($sformatf("v%0d_retired", i), retired, tbl[i].e_ret);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end

    // Invalid instruction at pc=5 retires, then stops with err.
    pc_track = 1'b1;
    pc = 32'd0;
    send(2'd0, 32'd0);
    for (int i = 0; i < 20 && state == 2'd2; i++) begin
      invalid_inst = (pc == 32'd5);
      cyc();
    end
    invalid_inst = 1'b0;
    chk("inv_halted", halted, 1);
    chk("inv_err", err, 1);
    chk("inv_bp_hit", bp_hit, 0);
    chk("inv_retired", retired, 34);
    chk("inv_pc", pc, 6);
    send(2'd0, 32'd0);
    chk("inv_resume_err", err, 0);
    chk("inv_resume_state", state, 2);

    // Breakpoint set while running, then reset mid-run loses it.
    send(2'd3, 32'h20);
    chk("setbp_run_state", state, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_pc_en", pc_en, 0);
    chk("midrst_state", state, 0);
    chk("midrst_retired", retired, 0);
    chk("midrst_ready", cmd_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pc = 32'h1E;
    repeat (4) cyc();
    chk("midrst_halted", halted, 1);
    send(2'd0, 32'd0);
    repeat (6) cyc();
    chk("postrst_pc", pc, 32'h24);
    chk("postrst_state", state, 2);
    chk("postrst_retired", retired, 6);
    chk("postrst_bp_hit", bp_hit, 0);
    send(2'd1, 32'd0);
    chk("final_halted", halted, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/halt/single-step sequencer for the single-cycle core. It drives the ProgramCounter's PCEn input and compares the current PC against one hardware breakpoint. It also stops the core on an invalid instruction and counts retired instructions. Commands arrive from a debug host over a valid/ready port; the block sits between that host and the core top.

Parameters:
PC_W, 32, width of PC, breakpoint address and command argument
CNT_W, 32, width of the retired-instruction counter
RST_HOLD, 4, cycles pc_en is held low after reset release (range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  block can accept a command
cmd_op  in  2  00 RUN, 01 HALT, 10 STEP, 11 SET_BP
cmd_arg  in  PC_W  breakpoint address for SET_BP; ignored otherwise
pc  in  PC_W  current PC from the ProgramCounter output
invalid_inst  in  1  ControlUnit InvalidInst for the current instruction
pc_en  out  1  to ProgramCounter PCEn; 1 = instruction executes and PC updates this cycle
halted  out  1  1 while in S_HALT
bp_hit  out  1  sticky: last stop was caused by the breakpoint
err  out  1  sticky: last stop was caused by invalid_inst
retired  out  CNT_W  count of cycles with pc_en=1
state  out  2  encoded FSM state, for debug

Behaviour:
- Reset values (asynchronous):
  - state=S_INIT, hold counter=RST_HOLD
  - bp_addr=0, bp_en=0, skip_bp=0
  - pc_en=0, halted=0, bp_hit=0, err=0, retired=0, cmd_ready=0
- States: S_INIT=0, S_HALT=1, S_RUN=2, S_STEP=3.
- S_INIT:
  - hold counter decrements each cycle.
  - At 1 -> S_HALT, so exactly RST_HOLD cycles are spent in S_INIT.
  - cmd_ready=0.
- cmd_ready=1 in every state except S_INIT. A command is accepted on a clk edge where cmd_valid and cmd_ready are both 1.
- pc_en is combinational:
  - pc_en = (state==S_RUN and !bp_block) or (state==S_STEP).
  - bp_block = bp_en and pc==bp_addr and !skip_bp.
- Command effects, taking place at the accepting edge:
  - RUN from S_HALT: -> S_RUN; set skip_bp=1; clear bp_hit and err.
  - RUN in S_RUN or S_STEP: no-op.
  - HALT from S_RUN or S_STEP: -> S_HALT. The accepting cycle still executes if pc_en=1.
  - HALT in S_HALT: no-op.
  - STEP from S_HALT: -> S_STEP; set skip_bp=1; clear bp_hit and err.
  - STEP in other states: no-op.
  - SET_BP, any state: bp_addr<=cmd_arg and bp_en<=1. cmd_arg of all-ones clears bp_en instead. State is unchanged.
- skip_bp is cleared on any edge where pc_en=1. Resuming from a breakpoint therefore executes that instruction once.
- S_STEP lasts exactly one cycle with pc_en=1, then -> S_HALT.
- In S_RUN with bp_block=1: pc_en=0 that cycle; next edge -> S_HALT with bp_hit<=1.
- Invalid instruction: on an edge where invalid_inst=1 and pc_en=1 -> S_HALT with err<=1. That cycle counts as retired.
- retired increments by 1 on every edge with pc_en=1. It wraps modulo 2^CNT_W with no flag.
- Simultaneous events:
  - Accepted HALT together with bp_block: -> S_HALT, bp_hit<=1.
  - Accepted HALT together with invalid_inst: -> S_HALT, err<=1.
  - Halt and sticky-flag causes are OR-ed; the resulting state is S_HALT.
- bp_block in S_RUN and invalid_inst cannot both count: pc_en=0, so invalid_inst is ignored.
- Reset asserted mid-operation:
  - Immediately: pc_en=0, FSM to S_INIT.
  - The breakpoint is lost, counters are cleared, and any in-flight command is dropped.

Decomposition:
- Shared package cpu_dbg_pkg holds:
  - state encoding constants S_INIT, S_HALT, S_RUN, S_STEP
  - command opcodes CMD_RUN, CMD_HALT, CMD_STEP, CMD_SET_BP
  - constant BP_DISABLE = all-ones
- One natural sub-module: bp_compare (registers bp_addr, bp_en and skip_bp; produces bp_block). The FSM and counters stay in cpu_run_ctrl.

Test Plan:
- Reset release with RST_HOLD=4, no commands -> pc_en=0 for 4 cycles; halted=1 from cycle 5; cmd_ready=1 from cycle 5; retired=0.
- RUN, then HALT after 10 cycles -> retired=10 (11 if HALT is accepted in the 11th pc_en cycle, counted exactly); halted=1; err=0; bp_hit=0.
- SET_BP 0x00000008, RUN from pc=0 -> pc_en=0 when pc==8; halted=1; bp_hit=1; retired=8. Then RUN -> pc_en=1 at pc=8, execution continues.
- From halt at pc=3, STEP three times -> exactly one pc_en pulse per STEP; retired +3; halted=1 after each step.
- RUN with invalid_inst=1 at pc=5 -> that cycle retires; then halted=1, err=1. RUN -> err clears.
- Assert rst while in S_RUN -> same-cycle pc_en=0 and state=S_INIT; after release, bp_en=0 (RUN passes the old bp address without stopping).
